// File: rtl/libv_queue_tx_pkg.sv
// Shared types and sizing helpers for the speculative commit/replay queue transmit engine.
package libv_queue_tx_pkg;

  typedef enum logic [1:0] {
    ST_SEND   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPLAY = 2'd2,
    ST_FLUSH  = 2'd3
  } tx_state_e;

  // Outstanding count must reach depth itself, hence one extra bit.
  function automatic int inflight_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/libv_queue_tx.sv
// Consumer-side transmit engine: pops queue entries downstream, commits on in-order ACK,
// go-back-N replays on NACK, and flushes after retry exhaustion or abort.
module libv_queue_tx
  import libv_queue_tx_pkg::*;
#(
  parameter int W         = 32,
  parameter int N         = 16,
  parameter int MAX_RETRY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     q_empty,
  input  logic [W-1:0]             q_pop_data,
  output logic                     q_pop,
  output logic                     q_commit,
  output logic                     q_replay,
  output logic                     q_flush,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [W-1:0]             out_data,
  input  logic                     rsp_vld,
  input  logic                     rsp_ok,
  input  logic                     abort,
  output logic [inflight_w(N)-1:0] inflight,
  output logic                     err,
  output logic                     busy
);

  localparam int IW = inflight_w(N);
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [IW-1:0] DEPTH      = IW'(N);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  tx_state_e     state_q, state_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          fatal_q, fatal_d;
  logic          abort_q, abort_d;
  logic          q_replay_q, q_replay_d;
  logic          q_flush_q, q_flush_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic nack_now, rsp_take, nack_take, in_send;

  // Data path and handshake are combinational so the popped beat is the accepted beat.
  always_comb begin
    in_send    = (state_q == ST_SEND);
    nack_now   = rsp_vld & ~rsp_ok;
    // A response with nothing outstanding is a protocol violation and is ignored.
    rsp_take   = rsp_vld & (inflight_q != '0);
    nack_take  = rsp_take & ~rsp_ok;
    out_data   = q_pop_data;
    out_vld    = rst & in_send & ~q_empty & (inflight_q < DEPTH) & ~nack_now & ~abort;
    q_pop      = out_vld & out_rdy;
    q_commit   = rst & in_send & rsp_take & rsp_ok;
    inflight_d = inflight_q + IW'(q_pop) - IW'(rsp_take);
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    retry_d = retry_q;
    fatal_d = fatal_q;
    abort_d = abort_q;
    unique case (state_q)
      ST_SEND: begin
        if (rsp_take && rsp_ok) retry_d = '0;
        if (nack_take) begin
          retry_d = (retry_q == RETRY_LAST) ? retry_q : RW'(retry_q + 1'b1);
          fatal_d = fatal_q | (retry_q == RETRY_LAST);
        end
        if (abort) abort_d = 1'b1;
        if (nack_take || abort) begin
          if (inflight_d != '0)         state_d = ST_DRAIN;
          else if (fatal_d || abort_d)  state_d = ST_FLUSH;
          else                          state_d = ST_REPLAY;
        end
      end
      ST_DRAIN: begin
        if (abort) abort_d = 1'b1;
        if (inflight_d == '0) state_d = (fatal_q || abort_d) ? ST_FLUSH : ST_REPLAY;
      end
      // An abort arriving during the rewind still ends in a flush.
      ST_REPLAY: state_d = abort ? ST_FLUSH : ST_SEND;
      ST_FLUSH: begin
        retry_d = '0;
        fatal_d = 1'b0;
        abort_d = 1'b0;
        state_d = ST_SEND;
      end
      default: state_d = ST_SEND;
    endcase

    q_replay_d = (state_d == ST_REPLAY);
    q_flush_d  = (state_d == ST_FLUSH);
    err_d      = (state_d == ST_FLUSH) & fatal_d;
    busy_d     = (state_d != ST_SEND) | (inflight_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SEND;
      inflight_q <= '0;
      retry_q    <= '0;
      fatal_q    <= 1'b0;
      abort_q    <= 1'b0;
      q_replay_q <= 1'b0;
      q_flush_q  <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      retry_q    <= retry_d;
      fatal_q    <= fatal_d;
      abort_q    <= abort_d;
      q_replay_q <= q_replay_d;
      q_flush_q  <= q_flush_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign q_replay = q_replay_q;
  assign q_flush  = q_flush_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign inflight = inflight_q;

  a_rsp_with_outstanding: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_vld && (inflight_q == '0)));

  a_queue_ctrl_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({q_pop, q_replay, q_flush}));

endmodule

// File: tb/tb_libv_queue_tx.sv
// Directed bench for libv_queue_tx: queue and downstream responder models with a
// scoreboard monitor comparing every accepted beat against pushed expectations.
module tb_libv_queue_tx;

  localparam int W         = 32;
  localparam int N         = 4;
  localparam int MAX_RETRY = 2;
  localparam int IW        = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          q_empty, q_pop, q_commit, q_replay, q_flush;
  logic [W-1:0]  q_pop_data, out_data;
  logic          out_vld, out_rdy, rsp_vld, rsp_ok, abort, err, busy;
  logic [IW-1:0] inflight;

  always #5 clk = ~clk;

  libv_queue_tx #(.W(W), .N(N), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_pop_data(q_pop_data),
    .q_pop(q_pop), .q_commit(q_commit), .q_replay(q_replay), .q_flush(q_flush),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .rsp_vld(rsp_vld), .rsp_ok(rsp_ok), .abort(abort),
    .inflight(inflight), .err(err), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Speculative queue model: write, speculative-read and architectural-read pointers.
  logic [W-1:0] qmem [16];
  int           wr_ptr, sp_ptr, ar_ptr;
  logic         tb_push;
  logic [W-1:0] tb_push_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 0; sp_ptr <= 0; ar_ptr <= 0;
    end else if (q_flush) begin
      wr_ptr <= 0; sp_ptr <= 0; ar_ptr <= 0;
    end else begin
      if (tb_push) begin
        qmem[wr_ptr % 16] <= tb_push_data;
        wr_ptr <= wr_ptr + 1;
      end
      if (q_replay)   sp_ptr <= ar_ptr;
      else if (q_pop) sp_ptr <= sp_ptr + 1;
      if (q_commit)   ar_ptr <= ar_ptr + 1;
    end
  end

  assign q_empty    = (sp_ptr == wr_ptr);
  assign q_pop_data = qmem[sp_ptr % 16];

  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q [$];
  int           pend [$];
  bit           ok_script [$];
  int           rsp_budget;
  int cnt_pop, cnt_commit, cnt_replay, cnt_flush, cnt_err, cnt_errflush, peak;

  // Monitor: sample between edges, score every accepted beat, schedule its response.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (q_pop)             cnt_pop++;
        if (q_commit)          cnt_commit++;
        if (q_replay)          cnt_replay++;
        if (q_flush)           cnt_flush++;
        if (err)               cnt_err++;
        if (err && q_flush)    cnt_errflush++;
        if (int'(inflight) > peak) peak = int'(inflight);
        if (out_vld && out_rdy) begin
          pend.push_back(cyc + 3);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got %h, expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              n_fail++;
              $display("FAIL beat_data: got %h, expected %h", out_data, e);
            end
          end
        end
      end
    end
  end

  // Downstream responder: one in-order response per beat, two cycles after acceptance.
  initial begin
    rsp_vld = 1'b0;
    rsp_ok  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rsp_vld = 1'b0;
      rsp_ok  = 1'b0;
      if (rst && pend.size() > 0 && pend[0] <= cyc + 1 && rsp_budget != 0) begin
        void'(pend.pop_front());
        rsp_vld = 1'b1;
        rsp_ok  = (ok_script.size() > 0) ? ok_script.pop_front() : 1'b1;
        if (rsp_budget > 0) rsp_budget--;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input bit expect_beat);
    tb_push      = 1'b1;
    tb_push_data = d;
    if (expect_beat) exp_q.push_back(d);
    tick();
    tb_push = 1'b0;
  endtask

  task automatic clr();
    cnt_pop = 0; cnt_commit = 0; cnt_replay = 0; cnt_flush = 0;
    cnt_err = 0; cnt_errflush = 0; peak = 0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (!busy && q_empty && pend.size() == 0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, max_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; out_rdy = 1'b1; abort = 1'b0; tb_push = 1'b0; tb_push_data = '0;
    rsp_budget = -1;
    clr();
    #3;
    check("rst_inflight", inflight, 0);
    check("rst_busy",     busy,     0);
    check("rst_ctrl",     {q_pop, q_commit, q_replay, q_flush, out_vld, err}, 0);
    repeat (3) tick();
    rst = 1'b1;

    // 1: four entries streamed and ACKed in order
    tick(); clr();
    for (int i = 0; i < 4; i++) push(32'hA0 + i, 1'b1);
    wait_idle("t1_idle", 50);
    check("t1_pops",     cnt_pop,    4);
    check("t1_commits",  cnt_commit, 4);
    check("t1_peak",     peak,       2);
    check("t1_inflight", inflight,   0);
    check("t1_replays",  cnt_replay, 0);

    // 2: ACK, NACK, ACK -> drain, one replay, entries 2 and 3 resent
    tick(); clr();
    ok_script = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) push(32'hB0 + i, 1'b1);
    exp_q.push_back(32'hB1);
    exp_q.push_back(32'hB2);
    wait_idle("t2_idle", 60);
    check("t2_commits", cnt_commit, 3);
    check("t2_replays", cnt_replay, 1);
    check("t2_pops",    cnt_pop,    5);
    check("t2_flushes", cnt_flush,  0);

    // 3: responses held -> window fills at N; a single ACK frees one slot
    tick(); clr();
    rsp_budget = 0;
    for (int i = 0; i < 6; i++) push(32'hC0 + i, 1'b1);
    repeat (8) tick();
    @(negedge clk);
    check("t3_pops_full",  cnt_pop,  4);
    check("t3_inflight",   inflight, 4);
    check("t3_vld_full",   out_vld,  0);
    check("t3_busy",       busy,     1);
    tick();
    rsp_budget = 1;
    repeat (6) tick();
    @(negedge clk);
    check("t3_pops_one",   cnt_pop,    5);
    check("t3_commit_one", cnt_commit, 1);
    check("t3_inflight2",  inflight,   4);
    tick();
    rsp_budget = -1;
    wait_idle("t3_idle", 80);
    check("t3_commits", cnt_commit, 6);

    // 4: NACK twice on one entry -> replay, then fatal flush with err
    tick(); clr();
    ok_script = '{1'b0, 1'b0};
    push(32'hD0, 1'b1);
    exp_q.push_back(32'hD0);
    wait_idle("t4_idle", 60);
    check("t4_replays",  cnt_replay,   1);
    check("t4_flushes",  cnt_flush,    1);
    check("t4_err",      cnt_err,      1);
    check("t4_errflush", cnt_errflush, 1);
    check("t4_commits",  cnt_commit,   0);
    // retry count was cleared by the flush: one NACK replays again rather than flushing
    tick(); clr();
    ok_script = '{1'b0, 1'b1};
    push(32'hD1, 1'b1);
    exp_q.push_back(32'hD1);
    wait_idle("t4b_idle", 60);
    check("t4b_replays", cnt_replay, 1);
    check("t4b_flushes", cnt_flush,  0);
    check("t4b_commits", cnt_commit, 1);

    // 5: abort with two outstanding -> drain, flush without err
    tick(); clr();
    rsp_budget = 0;
    push(32'hE0, 1'b1);
    push(32'hE1, 1'b1);
    repeat (3) tick();
    out_rdy = 1'b0;
    push(32'hE2, 1'b0);
    @(negedge clk);
    check("t5_inflight", inflight, 2);
    check("t5_vld_pre",  out_vld,  1);
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("t5_vld_abort", out_vld, 0);
    tick();
    abort = 1'b0; out_rdy = 1'b1; rsp_budget = -1;
    wait_idle("t5_idle", 40);
    check("t5_flushes", cnt_flush,  1);
    check("t5_err",     cnt_err,    0);
    check("t5_commits", cnt_commit, 0);
    check("t5_pops",    cnt_pop,    2);

    // 6: asynchronous reset in DRAIN with three outstanding
    tick(); clr();
    rsp_budget = 0;
    ok_script = '{1'b0};
    for (int i = 0; i < 4; i++) push(32'hF0 + i, 1'b1);
    repeat (4) tick();
    rsp_budget = 1;
    repeat (3) tick();
    @(negedge clk);
    check("t6_inflight", inflight, 3);
    check("t6_busy",     busy,     1);
    check("t6_vld",      out_vld,  0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_inflight", inflight, 0);
    check("t6_rst_busy",     busy,     0);
    check("t6_rst_ctrl",     {q_pop, q_commit, q_replay, q_flush, out_vld, err}, 0);
    pend.delete(); ok_script.delete(); exp_q.delete();
    rsp_budget = -1;
    tick(); tick();
    rst = 1'b1;
    clr();
    push(32'h55, 1'b1);
    wait_idle("t6_idle", 40);
    check("t6_pops",    cnt_pop,    1);
    check("t6_commits", cnt_commit, 1);

    check("exp_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
